// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: op encodings, FSM states and default latencies for the E-stage MDU
package e_mdu_pkg;
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8
    } mdu_op_t;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/e_mdu_core.sv
// e_mdu_core: combinational 64-bit multiply/divide/accumulate result from latched operands
module e_mdu_core
    import e_mdu_pkg::*;
(
    input  logic    [31:0] a,
    input  logic    [31:0] b,
    input  mdu_op_t        op,
    input  logic    [31:0] hi_in,
    input  logic    [31:0] lo_in,
    output logic    [63:0] res,
    output logic           wr
);
    logic [63:0] sp, up;
    logic [31:0] ma, mb, dv, q, r, qs, rs;
    logic        sgn;
    // Low 64 bits of a sign-extended product equal the signed product
    assign sp  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign up  = {32'b0, a} * {32'b0, b};
    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case
    assign sgn = op == MDU_DIV;
    assign ma  = sgn && a[31] ? -a : a;
    assign mb  = sgn && b[31] ? -b : b;
    assign dv  = mb == 32'd0 ? 32'd1 : mb;
    assign q   = ma / dv;
    assign r   = ma % dv;
    assign qs  = sgn && (a[31] ^ b[31]) ? -q : q;
    assign rs  = sgn && a[31] ? -r : r;
    assign res = op == MDU_MULT  ? sp :
                 op == MDU_MULTU ? up :
                 op == MDU_MADD  ? {hi_in, lo_in} + sp :
                 op == MDU_MADDU ? {hi_in, lo_in} + up :
                 {rs, qs};
    assign wr  = !((op == MDU_DIV || op == MDU_DIVU) && b == 32'd0);
endmodule

// File: rtl/e_mdu.sv
// e_mdu: MIPS E-stage multiply/divide unit with HI/LO and busy; MDU_MADD_EN enables MADD/MADDU
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);
    state_t        state;
    logic [CW-1:0] cnt;
    mdu_op_t       op_r;
    logic [31:0]   a_r, b_r;
    logic [63:0]   res;
    logic          wr, is_mul, is_div;
`ifdef MDU_MADD_EN
    assign is_mul = op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU};
`else
    assign is_mul = op inside {MDU_MULT, MDU_MULTU};
`endif
    assign is_div = op inside {MDU_DIV, MDU_DIVU};
    assign busy   = state == BUSY;
    e_mdu_core core (
        .a(a_r), .b(b_r), .op(op_r), .hi_in(hi), .lo_in(lo), .res(res), .wr(wr)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= MDU_NONE;
            a_r   <= '0;
            b_r   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (start && (is_mul || is_div)) begin
                op_r  <= mdu_op_t'(op);
                a_r   <= a;
                b_r   <= b;
                cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state <= BUSY;
            end else if (start && op == MDU_MTHI) begin
                hi <= a;
            end else if (start && op == MDU_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - 1'b1;
            // Counter reaches 0 on this edge: commit and release the pipeline
            if (cnt == CW'(1)) begin
                state <= IDLE;
                if (wr) {hi, lo} <= res;
            end
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized self-checking bench for e_mdu against a behavioural HI/LO model
module tb_e_mdu;
    import e_mdu_pkg::*;
    logic        clk = 0;
    logic        reset, start, busy;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] mhi = 0, mlo = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    e_mdu dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] o);
        if (o == 1 || o == 2) return 5;
        if (o == 3 || o == 4) return 10;
`ifdef MDU_MADD_EN
        if (o == 7 || o == 8) return 5;
`endif
        return 0;
    endfunction

    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        case (o)
            1: {mhi, mlo} = longint'(sx) * longint'(sy);
            2: {mhi, mlo} = 64'(x) * 64'(y);
            3: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    mlo = x;
                    mhi = 0;
                end else begin
                    mlo = sx / sy;
                    mhi = sx % sy;
                end
            end
            4: if (y != 0) begin
                mlo = x / y;
                mhi = x % y;
            end
            5: mhi = x;
            6: mlo = x;
`ifdef MDU_MADD_EN
            7: {mhi, mlo} = {mhi, mlo} + longint'(sx) * longint'(sy);
            8: {mhi, mlo} = {mhi, mlo} + 64'(x) * 64'(y);
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] oh, ol;
        int n;
        oh = mhi;
        ol = mlo;
        n = lat(o);
        start = 1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 0;
        op = 0;
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, 64'(busy), 64'(1));
            check({tag, " hold"}, {hi, lo}, {oh, ol});
            if (i == 2) begin
                start = 1;
                op = 4'($urandom_range(1, 6));
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            start = 0;
            op = 0;
        end
        model(o, x, y);
        check({tag, " idle"}, 64'(busy), 64'(0));
        check({tag, " hi"}, 64'(hi), 64'(mhi));
        check({tag, " lo"}, 64'(lo), 64'(mlo));
    endtask

    initial begin
        reset = 1;
        start = 0;
        op = 0;
        a = 0;
        b = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check("rst busy", 64'(busy), 64'(0));
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));

        run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, "mult");
        check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div");
        check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MDU_DIVU, 32'd7, 32'd2, "divu");
        check("divu const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(MDU_MTHI, 32'h1234_5678, 32'd0, "mthi");
        run_op(MDU_MTLO, 32'h9ABC_DEF0, 32'd0, "mtlo");
        check("mt const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(MDU_MTHI, 32'h55, 32'd0, "mthi55");
        run_op(MDU_MTLO, 32'h55, 32'd0, "mtlo55");
        run_op(MDU_DIV, 32'h1234, 32'd0, "div0");
        check("div0 const", {hi, lo}, 64'h0000_0055_0000_0055);
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        check("divovf const", {hi, lo}, 64'h0000_0000_8000_0000);

        // Reset during the third busy cycle of a multiply
        start = 1;
        op = MDU_MULT;
        a = 32'd3;
        b = 32'd4;
        @(posedge clk);
        #1;
        start = 0;
        op = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("abort busy pre", 64'(busy), 64'(1));
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        mhi = 0;
        mlo = 0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort hilo", {hi, lo}, 64'(0));
        repeat (6) @(posedge clk);
        #1;
        check("abort late busy", 64'(busy), 64'(0));
        check("abort late hilo", {hi, lo}, 64'(0));

        run_op(MDU_MTHI, 32'd0, 32'd0, "madd pre hi");
        run_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, "madd pre lo");
        run_op(MDU_MADDU, 32'd1, 32'd1, "maddu");
`ifdef MDU_MADD_EN
        check("maddu const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("maddu const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [31:0] x, y;
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(o, x, y, $sformatf("rnd%0d op%0d", i, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the pipelined MIPS core. Accepts one MULT/MULTU/DIV/DIVU (or MTHI/MTLO) per request, holds HI/LO, and raises `busy` for a fixed multi-cycle latency so the D-stage stall logic can hold dependent MFHI/MFLO and MD instructions. `hi`/`lo` feed the E-stage result mux.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for multiply ops
- DIV_CYCLES, 10, cycles `busy` stays high for divide ops

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous, active-high reset
- start  in  1  request strobe, sampled each edge
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU
- a  in  32  rs operand
- b  in  32  rt operand
- busy  out  1  computation in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU (MADD/MADDU if enabled): latch a, b, op; load counter with MULT_CYCLES or DIV_CYCLES; go BUSY.
- IDLE, start=1, op MTHI/MTLO: hi<=a or lo<=a at that edge; stay IDLE; busy stays 0.
- start=1 with op NONE or unknown: no effect.
- BUSY: counter decrements each edge; at the edge where counter reaches 0, write hi/lo, go IDLE.
- start while BUSY: ignored (pipeline guarantees it cannot occur; no queueing).
- MULT: {hi,lo} = signed a × signed b, 64-bit. MULTU: unsigned.
- DIV: lo = a/b signed, truncated toward zero; hi = remainder, sign of a. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0): busy runs full DIV_CYCLES; hi/lo unchanged.
- hi/lo hold the old values throughout BUSY; new values visible only after completion.

## Timing
- Reset: busy=0, hi=0, lo=0, state IDLE, counter 0. Reset mid-operation aborts; no hi/lo write.
- start sampled at edge T: busy=1 from T+1 through T+N (N = MULT_CYCLES/DIV_CYCLES), hi/lo updated at edge T+N, busy=0 at T+N after that edge... precisely: busy high for exactly N cycles, result readable in cycle following the last busy cycle.
- Stall logic uses (start | busy); the unit itself does not stall.
- MTHI/MTLO: 1-cycle, result visible the cycle after start.
- Back-to-back: new start accepted in the first cycle busy=0 again.

## Configuration
- MDU_MADD_EN defined: op 7 MADD gives {hi,lo} += signed a×b, op 8 MADDU unsigned; MULT latency, accumulate uses hi/lo as of completion edge.
- Undefined: ops 7/8 treated as NONE (no busy, no hi/lo change).

## Structure
- Shared package: op encodings (MDU_NONE..MDU_MADDU), state enum, default latencies.
- One sub-module natural: e_mdu_core, purely combinational 64-bit multiply/divide result from latched operands and op; e_mdu holds FSM, counter, HI/LO.

## Test plan
- Reset then MULT a=0xFFFFFFFF b=2 -> busy high 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> busy never 1, hi/lo take values one cycle after each start.
- hi=lo=0x55 preloaded, DIV b=0 -> busy 10 cycles, hi/lo remain 0x55; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MULT started, reset asserted at 3rd busy cycle -> busy=0, hi=lo=0 next cycle, no later write; start during busy -> ignored, result of first op only.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1 b=1 -> hi=1, lo=0; without: same stimulus -> no busy, hi/lo unchanged.
